mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Shares the single-port unified memory between the instruction-fetch path and the load/store data path of the MIPS32 core. It arbitrates the two requesters round-robin and sequences each access through a request/ready handshake with the memory. It raises a stall to the process unit while any access is outstanding, and aborts hung accesses with a sticky timeout flag. It sits between the process unit's fetch/memory stages and the memory model.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_WAIT, 15, max wait cycles for MemReady before abort (≥1)

- Clk  in  1  clock, rising edge
- Reset  in  1  asynchronous, active-high
- IfReq  in  1  fetch request, held until IfAck
- IfAddr  in  ADDR_W  fetch address, stable while IfReq
- IfRData  out  DATA_W  fetched word, valid with IfAck
- IfAck  out  1  one-cycle fetch completion pulse
- DReq  in  1  data request, held until DAck
- DWe  in  1  1 = store, 0 = load; stable while DReq
- DAddr  in  ADDR_W  data address
- DWData  in  DATA_W  store data
- DRData  out  DATA_W  load data, valid with DAck
- DAck  out  1  one-cycle data completion pulse
- MemReq  out  1  memory access strobe, held until MemReady or abort
- MemWe  out  1  memory write enable
- MemAddr  out  ADDR_W  memory address
- MemWData  out  DATA_W  memory write data
- MemRData  in  DATA_W  memory read data, valid with MemReady
- MemReady  in  1  memory completion
- Stall  out  1  combinational: (IfReq & ~IfAck) | (DReq & ~DAck)
- Busy  out  1  state ≠ IDLE
- ErrTimeout  out  1  sticky abort flag, cleared only by Reset

## Operation
- States: IDLE, ACC_IF, ACC_D, RESP.
- IDLE: if only one Req is high, grant it; if both, grant the one not in LastGrant; if none, stay.
- Grant loads MemAddr/MemWe/MemWData from the winner (MemWe = 0 for IF), sets MemReq = 1, clears WaitCnt, updates LastGrant, and moves to ACC_IF/ACC_D.
- ACC_x, MemReady = 1: latch MemRData (0 for stores) into the winner's RData, drop MemReq, go to RESP.
- ACC_x, MemReady = 0 and WaitCnt = MAX_WAIT: abort. Drop MemReq, RData = 0, set ErrTimeout, go to RESP.
- ACC_x otherwise: WaitCnt += 1. WaitCnt is $clog2(MAX_WAIT+1) bits and never wraps.
- MemReady and WaitCnt = MAX_WAIT together: success wins, and ErrTimeout is not set.
- RESP: assert the winner's Ack for exactly one cycle, then go to IDLE. Requesters drop or replace Req at the edge that ends the Ack cycle.
- MemReady in IDLE/RESP is ignored.
- Req dropping mid-access is illegal and ignored; the access completes.
- RData registers hold their value between acks.

## Timing
- All outputs except Stall are registered.
- Reset (async) values:
  - state IDLE
  - MemReq, MemWe, IfAck, DAck, ErrTimeout all 0
  - MemAddr, MemWData, IfRData, DRData all 0
  - WaitCnt 0
  - LastGrant = IF, so the first tie goes to D
- Reset mid-access abandons the access immediately, with no Ack.
- Latency, with Req high in cycle t while IDLE:
  - MemReq = 1 in t+1
  - MemReady high in cycle t+1+n gives Ack in t+2+n
  - IDLE in t+3+n
- Minimum 3 cycles per access (n = 0). A new grant is possible in the IDLE cycle after RESP.
- Abort: MemReq stays high MAX_WAIT+1 cycles; Ack arrives the cycle after the last one.
- ErrTimeout rises in the same cycle as the aborted Ack.

## Test plan
- Fetch with zero wait:
  - Stimulus: IfReq at t0, IfAddr = 0x00400000; memory returns 0x8C020004 with MemReady in t1.
  - Required: MemReq high only in t1, MemWe = 0, IfAck in t2 with IfRData = 0x8C020004, Stall low from t3, DAck never.
- Tie after reset:
  - Stimulus: IfReq and DReq (load, DAddr = 0x10010000) both high at t0; memory ready 1 cycle after each MemReq.
  - Required: D is served first, DAck at t2; IF is granted at t3 with MemReq in t4, IfAck at t5. A further tie then goes to D again.
- Store with wait states:
  - Stimulus: DReq, DWe = 1, DAddr = 0x10010008, DWData = 0x12345678; MemReady after 4 low cycles.
  - Required: MemWe = 1, MemWData = 0x12345678, MemReq held 5 cycles; DAck one cycle later with DRData = 0; Stall high throughout.
- Timeout:
  - Stimulus: MAX_WAIT = 3, IfReq, MemReady held 0.
  - Required: MemReq high for exactly 4 cycles, then IfAck with IfRData = 0 and ErrTimeout = 1, staying 1 through later successful accesses until Reset.
- Boundary:
  - Stimulus: MemReady rises in the same cycle WaitCnt = MAX_WAIT.
  - Required: normal completion with MemRData returned; ErrTimeout stays 0.
- Reset mid-access:
  - Stimulus: Reset pulses while ACC_D with MemReq high.
  - Required: MemReq, DAck and Busy go 0 asynchronously, no Ack is issued, and the next tie grants D.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port memory between the instruction-fetch requester (If*)
// and the load/store requester (D*). Requests are granted round-robin,
// each access is carried through a MemReq/MemReady handshake, and an access
// that waits too long is aborted with a sticky ErrTimeout flag.
//
// Ports
//   Clk, Reset           clock (rising edge), asynchronous active-high reset
//   IfReq/IfAddr         fetch request and address (held until IfAck)
//   IfRData/IfAck        fetched word and its one-cycle completion pulse
//   DReq/DWe/DAddr/DWData  data request, store flag, address, store data
//   DRData/DAck          load data and its one-cycle completion pulse
//   MemReq/MemWe/MemAddr/MemWData  memory strobe and access fields
//   MemRData/MemReady    memory read data and completion
//   Stall                combinational stall to the process unit
//   Busy                 arbiter is not idle
//   ErrTimeout           sticky abort flag, cleared only by Reset
//   DbgState             current FSM state (IDLE=0, ACC_IF=1, ACC_D=2, RESP=3)
//
// Handshake: a requester raises Req with stable fields and holds it until its
// Ack pulse; the Ack cycle is the last cycle the Req is observed, and the
// requester may drop or replace it at the edge that ends that cycle. On the
// memory side MemReq is held with stable fields until MemReady is seen high
// at a rising edge, or until the access is aborted.

module mem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              IfReq,
    input  logic [ADDR_W-1:0] IfAddr,
    output logic [DATA_W-1:0] IfRData,
    output logic              IfAck,
    input  logic              DReq,
    input  logic              DWe,
    input  logic [ADDR_W-1:0] DAddr,
    input  logic [DATA_W-1:0] DWData,
    output logic [DATA_W-1:0] DRData,
    output logic              DAck,
    output logic              MemReq,
    output logic              MemWe,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [DATA_W-1:0] MemWData,
    input  logic [DATA_W-1:0] MemRData,
    input  logic              MemReady,
    output logic              Stall,
    output logic              Busy,
    output logic              ErrTimeout,
    output logic [1:0]        DbgState
);

    localparam int CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACC_IF = 2'd1,
        ACC_D  = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  wait_cnt;
    logic              last_is_d;   // 0 = fetch was granted last, 1 = data
    logic              grant_d;
    logic              grant_if;
    logic [DATA_W-1:0] read_word;

    // On a tie the requester that was not granted last wins.
    assign grant_d  = DReq & (~IfReq | ~last_is_d);
    assign grant_if = IfReq & ~grant_d;

    // Stores return zero as their read data.
    assign read_word = MemWe ? '0 : MemRData;

    assign Stall    = (IfReq & ~IfAck) | (DReq & ~DAck);
    assign Busy     = (state != IDLE);
    assign DbgState = state;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            last_is_d  <= 1'b0;
            MemReq     <= 1'b0;
            MemWe      <= 1'b0;
            MemAddr    <= '0;
            MemWData   <= '0;
            IfRData    <= '0;
            DRData     <= '0;
            IfAck      <= 1'b0;
            DAck       <= 1'b0;
            ErrTimeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        MemAddr   <= DAddr;
                        MemWe     <= DWe;
                        MemWData  <= DWData;
                        MemReq    <= 1'b1;
                        wait_cnt  <= '0;
                        last_is_d <= 1'b1;
                        state     <= ACC_D;
                    end else if (grant_if) begin
                        MemAddr   <= IfAddr;
                        MemWe     <= 1'b0;
                        MemWData  <= '0;
                        MemReq    <= 1'b1;
                        wait_cnt  <= '0;
                        last_is_d <= 1'b0;
                        state     <= ACC_IF;
                    end
                end

                ACC_IF, ACC_D: begin
                    // Completion is checked first so a MemReady that arrives
                    // on the final allowed cycle still counts as success.
                    if (MemReady || (wait_cnt == WAIT_LIMIT)) begin
                        MemReq <= 1'b0;
                        state  <= RESP;
                        if (state == ACC_IF) begin
                            IfRData <= MemReady ? read_word : '0;
                            IfAck   <= 1'b1;
                        end else begin
                            DRData <= MemReady ? read_word : '0;
                            DAck   <= 1'b1;
                        end
                        if (!MemReady) begin
                            ErrTimeout <= 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end

                RESP: begin
                    IfAck <= 1'b0;
                    DAck  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
